ls_counter: RTL and testbench

Parametrised synchronous counter modelled on the 74LS161/163/169 family. It supplies the horizontal/vertical timing chains, the score counters and the paddle/ball position counters in the TTL-level game recreation. It replaces hard-coded per-chip counter models with one block, generalised in width, modulus, clear mode and count direction. Chip-clock edges arrive as a single-cycle enable on the system clock, so the whole design stays on one clock.

---
 rtl/ls_pkg.sv | 49 ++++
 rtl/ls_counter.sv | 91 +++++++++
 tb/tb_ls_counter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ls_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ls_pkg
// Description : Shared constants and next-count helper for the 74LS161/163/169
//               style counter models.
// Revision    : 1.0 - initial release
// ============================================================================
package ls_pkg;

    // Clear-mode selectors for the CLR_SYNC parameter.
    localparam int LS_CLR_SYNC  = 1;
    localparam int LS_CLR_ASYNC = 0;

    // Widest counter the helper below supports.
    localparam int LS_MAX_WIDTH = 16;

    // Next count value for a counter of 'width' bits cycling over 'modulus'
    // states. Counting up from the terminal value wraps to zero; an
    // out-of-range value keeps incrementing modulo 2**width. Counting down
    // from zero reloads modulus-1; anything else simply decrements.
    function automatic logic [15:0] ls_next_count(
        input logic [15:0] q,
        input logic        up,
        input logic [16:0] modulus,
        input int          width
    );
        logic [15:0] v_mask;
        logic [15:0] v_term;
        logic [15:0] v_next;
        v_mask = 16'((17'd1 << width) - 17'd1);
        v_term = 16'(modulus - 17'd1);
        if (up) begin
            if (q == v_term) begin
                v_next = 16'd0;
            end else begin
                v_next = (q + 16'd1) & v_mask;
            end
        end else begin
            if (q == 16'd0) begin
                v_next = v_term;
            end else begin
                v_next = q - 16'd1;
            end
        end
        return v_next;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ls_counter.sv
`default_nettype none
// ============================================================================
// Module      : ls_counter
// Description : Parametrised synchronous counter covering the 74LS161/163/169
//               family. Chip-clock edges arrive as a one-cycle 'ce' strobe on
//               the system clock; 'rco' is combinational for cascading.
// Revision    : 1.0 - initial release
// ============================================================================
module ls_counter
    import ls_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int CLR_SYNC = LS_CLR_SYNC,
    parameter int UPDOWN   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr_n,
    input  logic             load_n,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    localparam logic [WIDTH-1:0] c_term_up = WIDTH'(MODULUS - 1);
    localparam logic [16:0]      c_modulus = 17'(MODULUS);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_vis;
    logic [WIDTH-1:0] w_q_next;
    logic [15:0]      w_q_ext;
    logic [15:0]      w_next_ext;
    logic             w_up;
    logic             w_clr_fire;
    logic             w_clr_mask;

    // Without the up/down option the counter always runs upward.
    assign w_up = up | (UPDOWN == 0);

    // Next value through the shared helper, which works on 16-bit values.
    assign w_q_ext    = 16'(r_q);
    assign w_next_ext = ls_next_count(w_q_ext, w_up, c_modulus, WIDTH);
    assign w_q_next   = w_next_ext[WIDTH-1:0];

    // Upper helper bits are always zero for narrower counters.
    generate
        if (WIDTH < LS_MAX_WIDTH) begin : g_hi_pad
            logic [LS_MAX_WIDTH-1-WIDTH:0] w_unused_hi;
            assign w_unused_hi = w_next_ext[LS_MAX_WIDTH-1:WIDTH];
        end
    endgenerate

    // 163-style clear waits for a chip clock; 161-style clear acts on every
    // system edge and also masks the output immediately.
    generate
        if (CLR_SYNC != LS_CLR_ASYNC) begin : g_clr_sync
            assign w_clr_fire = ce & ~clr_n;
            assign w_clr_mask = 1'b0;
        end else begin : g_clr_async
            assign w_clr_fire = ~clr_n;
            assign w_clr_mask = ~clr_n;
        end
    endgenerate

    // Count register: reset, clear, load, count, hold in priority order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (w_clr_fire) begin
            r_q <= '0;
        end else if (ce && !load_n) begin
            r_q <= d;
        end else if (ce && enp && ent) begin
            r_q <= w_q_next;
        end
    end

    // Visible count, zeroed at once while an asynchronous-style clear is held.
    assign w_q_vis = w_clr_mask ? '0 : r_q;
    assign q       = w_q_vis;

    // Ripple carry from the visible count; no ce gating so stages can chain.
    assign rco = ent & (w_up ? (w_q_vis == c_term_up) : (w_q_vis == '0));

endmodule
`default_nettype wire

// File: tb/tb_ls_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ls_counter
// Description : Self-checking bench for ls_counter: a vector table on an
//               up/down mod-10 counter plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ls_counter;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       ce;
    logic       clr_n;
    logic       load_n;
    logic       enp;
    logic       ent;
    logic       up;
    logic [3:0] d4;
    logic [8:0] d9;

    logic [3:0] qa, qc, qd;
    logic [8:0] qb;
    logic       rcoa, rcob, rcoc, rcod;

    int total;
    int bad;

    // A: mod-16 up, sync clear
    ls_counter #(.WIDTH(4), .MODULUS(16), .CLR_SYNC(1), .UPDOWN(0)) u_a (
        .clk(clk), .rst(rst), .ce(ce), .clr_n(clr_n), .load_n(load_n),
        .enp(enp), .ent(ent), .up(up), .d(d4), .q(qa), .rco(rcoa));
    // B: mod-455 up
    ls_counter #(.WIDTH(9), .MODULUS(455), .CLR_SYNC(1), .UPDOWN(0)) u_b (
        .clk(clk), .rst(rst), .ce(ce), .clr_n(clr_n), .load_n(load_n),
        .enp(enp), .ent(ent), .up(up), .d(d9), .q(qb), .rco(rcob));
    // C: mod-16 up, async-style clear
    ls_counter #(.WIDTH(4), .MODULUS(16), .CLR_SYNC(0), .UPDOWN(0)) u_c (
        .clk(clk), .rst(rst), .ce(ce), .clr_n(clr_n), .load_n(load_n),
        .enp(enp), .ent(ent), .up(up), .d(d4), .q(qc), .rco(rcoc));
    // D: mod-10 up/down, sync clear
    ls_counter #(.WIDTH(4), .MODULUS(10), .CLR_SYNC(1), .UPDOWN(1)) u_d (
        .clk(clk), .rst(rst), .ce(ce), .clr_n(clr_n), .load_n(load_n),
        .enp(enp), .ent(ent), .up(up), .d(d4), .q(qd), .rco(rcod));

    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        logic       ce;
        logic       clr_n;
        logic       load_n;
        logic       enp;
        logic       ent;
        logic       up;
        logic [3:0] d;
        logic [3:0] q;
        logic       rco;
    } vec_t;

    vec_t vecs[$];

    task automatic vadd(input logic c, input logic cl, input logic ld,
                        input logic p, input logic t, input logic u,
                        input logic [3:0] dd, input logic [3:0] eq,
                        input logic er);
        vec_t v;
        v.ce = c; v.clr_n = cl; v.load_n = ld; v.enp = p; v.ent = t;
        v.up = u; v.d = dd; v.q = eq; v.rco = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_q;
        total = 0; bad = 0;
        clk = 1'b0; clk_run = 1'b1; rst = 1'b0;
        ce = 1'b0; clr_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b1;
        up = 1'b0; d4 = 4'd0; d9 = 9'd0;

        // Reset state, asynchronous before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_qa", 32'(qa), 0);
        chk("rst_qd", 32'(qd), 0);
        chk("rst_rcoa", 32'(rcoa), 0);
        chk("rst_rcod_down", 32'(rcod), 1);
        tick();
        rst = 1'b0;

        // Mod-16 up count with rco at 15
        ce = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_q = (i + 1) % 16;
            chk("a_count_q", 32'(qa), 32'(exp_q));
            chk("a_count_rco", 32'(rcoa), (exp_q == 15) ? 1 : 0);
        end

        // Odd modulus wrap 453, 454, 0 with ent gating
        load_n = 1'b0; d9 = 9'd453;
        tick();
        chk("b_load_q", 32'(qb), 453);
        chk("b_load_rco", 32'(rcob), 0);
        load_n = 1'b1;
        tick();
        chk("b_454_q", 32'(qb), 454);
        chk("b_454_rco", 32'(rcob), 1);
        ent = 1'b0;
        #1;
        chk("b_ent0_rco", 32'(rcob), 0);
        tick();
        chk("b_hold_q", 32'(qb), 454);
        chk("b_hold_rco", 32'(rcob), 0);
        ent = 1'b1;
        tick();
        chk("b_wrap_q", 32'(qb), 0);

        // Clear modes from 7 with ce low
        load_n = 1'b0; d4 = 4'd7;
        tick();
        chk("clr_a_load", 32'(qa), 7);
        chk("clr_c_load", 32'(qc), 7);
        load_n = 1'b1; ce = 1'b0; clr_n = 1'b0;
        #1;
        chk("clr_a_comb_hold", 32'(qa), 7);
        chk("clr_c_comb_zero", 32'(qc), 0);
        tick();
        chk("clr_a_noce", 32'(qa), 7);
        chk("clr_c_edge", 32'(qc), 0);
        ce = 1'b1;
        tick();
        chk("clr_a_ce", 32'(qa), 0);
        clr_n = 1'b1; ce = 1'b0;
        #1;
        chk("clr_c_reg", 32'(qc), 0);

        // Vector table on the mod-10 up/down counter
        //    ce    clr_n load_n enp   ent   up    d      q      rco
        vadd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  4'd1,  1'b0);
        vadd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1);
        vadd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9,  1'b0);
        vadd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd8,  1'b0);
        vadd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd9,  1'b1);
        vadd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0);
        vadd(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0);
        vadd(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0);
        vadd(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5,  4'd0,  1'b0);
        vadd(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  4'd5,  1'b0);
        vadd(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  4'd3,  1'b0);
        vadd(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd14, 4'd14, 1'b0);
        vadd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd15, 1'b0);
        vadd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0);
        vadd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd1,  1'b0);
        vadd(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd14, 4'd14, 1'b0);
        vadd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd13, 1'b0);
        vadd(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd13, 1'b0);
        vadd(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1);
        vadd(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            ce = vecs[i].ce; clr_n = vecs[i].clr_n; load_n = vecs[i].load_n;
            enp = vecs[i].enp; ent = vecs[i].ent; up = vecs[i].up;
            d4 = vecs[i].d;
            tick();
            chk($sformatf("vec%0d_q", i), 32'(qd), 32'(vecs[i].q));
            chk($sformatf("vec%0d_rco", i), 32'(rcod), 32'(vecs[i].rco));
        end

        // Asynchronous reset with the clock stopped, then fresh ce needed
        ce = 1'b1; clr_n = 1'b1; load_n = 1'b0; enp = 1'b1; ent = 1'b1;
        up = 1'b1; d4 = 4'd6;
        tick();
        chk("rst_pre_qd", 32'(qd), 6);
        load_n = 1'b1; ce = 1'b0;
        @(negedge clk);
        clk_run = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_stopped_qd", 32'(qd), 0);
        chk("rst_stopped_qa", 32'(qa), 0);
        #3 rst = 1'b0;
        clk_run = 1'b1;
        tick();
        chk("rst_noce_hold", 32'(qd), 0);
        ce = 1'b1;
        tick();
        chk("rst_first_count", 32'(qd), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
